uart_tx_ctrl: RTL

UART transmitter for the CPU's serial peripheral: the sending counterpart to the CPU's `UART_RX` receive path. It accepts bytes from the CPU-side write strobe into a small FIFO and serialises them on `UART_TX` as 8N1 frames at 9600 baud from the 50 MHz `sysclk`. Frames are sent LSB first, with back-to-back frames when the FIFO holds more data.

---
 rtl/uart_tx_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter fed by a small write FIFO.
// Frames go out LSB first, back-to-back while the FIFO holds data.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          UART_TX
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          empty;
    logic          bit_end;
    logic [7:0]    head;

    assign tx_full = (fifo_count == CNT_FULL);
    assign tx_busy = (state != IDLE);
    assign empty   = (fifo_count == '0);
    assign push    = tx_wr && !tx_full;
    assign bit_end = (baud == BAUD_LAST);
    // A byte written on the final stop cycle bypasses the empty FIFO
    assign head    = empty ? tx_data : mem[rd_ptr];

    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            STOP:    pop = bit_end && (!empty || push);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_ONE;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state   <= IDLE;
            UART_TX <= 1'b1;
            tx_done <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            tx_done <= 1'b0;
            // Every state change happens on bit_end, so the wrap doubles as the reset
            baud    <= bit_end ? '0 : baud + 1'b1;
            unique case (state)
                IDLE: begin
                    baud    <= '0;
                    UART_TX <= 1'b1;
                    if (pop) begin
                        shift   <= head;
                        state   <= START;
                        UART_TX <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        UART_TX <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            UART_TX <= 1'b1;
                        end else begin
                            UART_TX <= shift[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        if (pop) begin
                            shift   <= head;
                            state   <= START;
                            UART_TX <= 1'b0;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
